// File: rtl/one_wire_master_if.sv
// Host-side command/status and pin signals of one 1-wire bus master.
// The master modport is the view of one_wire_master itself; the slave
// modport is the view of whatever drives commands and models the pin.
interface one_wire_master_if;
    logic       cmdWrite;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       presence;
    logic       shortError;
    logic       busy;
    logic       done;
    logic       busIn;
    logic       busPullLow;

    modport master (
        input  cmdWrite, cmd, wdata, busIn,
        output rdata, presence, shortError, busy, done, busPullLow
    );

    modport slave (
        output cmdWrite, cmd, wdata, busIn,
        input  rdata, presence, shortError, busy, done, busPullLow
    );
endinterface

// File: rtl/one_wire_master.sv
// 1-wire bus master: sequences reset/presence, byte (LSB first) and single
// bit slots on one open-drain pin, timed by a microsecond prescaler.
// Optional macro ONE_WIRE_SHORT_DETECT_EN aborts a command when the bus is
// already low at command accept or at a slot start.
module one_wire_master #(
    parameter int US_DIVIDER         = 29,
    parameter int RESET_LOW_US       = 480,
    parameter int PRESENCE_SAMPLE_US = 70,
    parameter int RESET_RELEASE_US   = 480,
    parameter int SLOT_US            = 65,
    parameter int WRITE1_LOW_US      = 6,
    parameter int WRITE0_LOW_US      = 60,
    parameter int SAMPLE_US          = 15
) (
    input logic              clk,
    input logic              reset,
    one_wire_master_if.master bus
);

    localparam int             DW        = $clog2(US_DIVIDER);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(US_DIVIDER - 1);
    localparam logic [9:0]     T_RST_LOW = 10'(RESET_LOW_US);
    localparam logic [9:0]     T_PRES    = 10'(PRESENCE_SAMPLE_US);
    localparam logic [9:0]     T_REL     = 10'(RESET_RELEASE_US);
    localparam logic [9:0]     T_SLOT    = 10'(SLOT_US);
    localparam logic [9:0]     T_W1      = 10'(WRITE1_LOW_US);
    localparam logic [9:0]     T_W0      = 10'(WRITE0_LOW_US);
    localparam logic [9:0]     T_SAMPLE  = 10'(SAMPLE_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_REL,
        S_SLOT,
        S_ABORT
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q;
    logic [9:0]      t_q;
    logic [7:0]      data_q;
    logic [7:0]      shift_q;
    logic [2:0]      bitcnt_q;
    logic            byte_q;
    logic [7:0]      rdata_q;
    logic            presence_q;
    logic            busy_q;
    logic            done_q;
    logic            pull_q;
    logic            sync1_q;
    logic            bus_sync_q;

    logic            tick;
    logic [9:0]      t_inc;
    logic [9:0]      low_time;
    logic            accept;
    logic            last_slot;

    // Two-flop synchronizer for the asynchronous pin level; idles high like the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            bus_sync_q <= 1'b1;
        end else begin
            sync1_q    <= bus.busIn;
            bus_sync_q <= sync1_q;
        end
    end

    // Prescaler terminal count, µs increment, current bit's low time and accept.
    always_comb begin
        tick      = (div_q == DIV_LAST);
        t_inc     = t_q + 10'd1;
        low_time  = data_q[0] ? T_W1 : T_W0;
        accept    = bus.cmdWrite && (bus.cmd != 2'b00) && (state_q == S_IDLE);
        last_slot = !byte_q || (bitcnt_q == 3'd7);
    end

`ifdef ONE_WIRE_SHORT_DETECT_EN
    logic short_q;
`endif

    // Command sequencer with registered bus and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            t_q        <= '0;
            data_q     <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            byte_q     <= 1'b0;
            rdata_q    <= '0;
            presence_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pull_q     <= 1'b0;
`ifdef ONE_WIRE_SHORT_DETECT_EN
            short_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            div_q  <= tick ? '0 : div_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        div_q    <= '0;
                        t_q      <= '0;
                        data_q   <= bus.wdata;
                        bitcnt_q <= '0;
                        byte_q   <= (bus.cmd == 2'b10);
                        busy_q   <= 1'b1;
                        pull_q   <= 1'b1;
                        state_q  <= (bus.cmd == 2'b01) ? S_RST_LOW : S_SLOT;
`ifdef ONE_WIRE_SHORT_DETECT_EN
                        // A bus already low overrides the start: stay released and abort.
                        short_q  <= ~bus_sync_q;
                        if (!bus_sync_q) begin
                            pull_q  <= 1'b0;
                            state_q <= S_ABORT;
                        end
`endif
                    end
                end
                S_RST_LOW: begin
                    if (tick) begin
                        t_q <= t_inc;
                        if (t_inc == T_RST_LOW) begin
                            t_q     <= '0;
                            pull_q  <= 1'b0;
                            state_q <= S_RST_REL;
                        end
                    end
                end
                S_RST_REL: begin
                    if (tick) begin
                        t_q <= t_inc;
                        if (t_inc == T_PRES) begin
                            presence_q <= ~bus_sync_q;
                        end
                        if (t_inc == T_REL) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SLOT: begin
                    if (tick) begin
                        t_q    <= t_inc;
                        pull_q <= (t_inc < low_time);
                        if (t_inc == T_SAMPLE) begin
                            shift_q <= {bus_sync_q, shift_q[7:1]};
                        end
                        if (t_inc == T_SLOT) begin
                            if (last_slot) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pull_q  <= 1'b0;
                                rdata_q <= byte_q ? shift_q : {7'b0, shift_q[7]};
                            end else begin
                                // Next slot starts with no gap; every low time is at least 1 µs.
                                t_q      <= '0;
                                bitcnt_q <= bitcnt_q + 3'd1;
                                data_q   <= {1'b0, data_q[7:1]};
                                pull_q   <= 1'b1;
`ifdef ONE_WIRE_SHORT_DETECT_EN
                                if (!bus_sync_q) begin
                                    short_q <= 1'b1;
                                    pull_q  <= 1'b0;
                                    state_q <= S_ABORT;
                                end
`endif
                            end
                        end
                    end
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.presence   = presence_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.busPullLow = pull_q;
`ifdef ONE_WIRE_SHORT_DETECT_EN
    assign bus.shortError = short_q;
`else
    assign bus.shortError = 1'b0;
`endif

endmodule

// File: tb/tb_one_wire_master.sv
// Bench for one_wire_master: table of commands plus randomized bytes checked
// against a slot-level model (low time per bit, device-forced zeros, presence window).
`timescale 1ns/1ps
module tb_one_wire_master;

    localparam int D       = 4;
    localparam int LIMIT   = 1200 * D;
    localparam int M_NONE  = 0;
    localparam int M_SLOT  = 1;
    localparam int M_PRES  = 2;
    localparam int M_STUCK = 3;

    logic clk = 1'b0;
    logic reset;
    logic dev_low = 1'b0;

    one_wire_master_if ifc();
    assign ifc.busIn = ~(ifc.busPullLow | dev_low);

    one_wire_master #(.US_DIVIDER(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;

    // Monitor / device model state
    int         cyc = 0;
    int         rise_t = 0;
    int         rel_t = -1000000;
    int         dev_cnt = 0;
    int         slot_i = 0;
    int         done_cnt = 0;
    int         busy_cyc = 0;
    int         rdata_chg = 0;
    bit         have_rise = 0;
    logic       pull_p = 1'b0;
    logic [7:0] rdata_p = 8'h00;
    int         lows[$];
    int         periods[$];
    int         dev_mode = M_NONE;
    logic [7:0] dev_mask = 8'h00;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wd;
        int         mode;
        logic [7:0] mask;
        int         inject;
        logic [7:0] exp_rdata;
        logic       exp_pres;
    } vec_t;

    vec_t vecs[9];
    logic cur_pres;

    task automatic chk(input string nm, input bit ok, input int act, input int exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Pin-level observer plus device behaviour, sampled on the falling clock edge.
    always @(negedge clk) begin
        cyc++;
        if (ifc.busPullLow && !pull_p) begin
            if (have_rise) periods.push_back(cyc - rise_t);
            rise_t    = cyc;
            have_rise = 1;
            if (dev_mode == M_SLOT && slot_i < 8 && dev_mask[slot_i]) dev_cnt = 30 * D;
            slot_i++;
        end
        if (!ifc.busPullLow && pull_p) begin
            lows.push_back(cyc - rise_t);
            if (cyc - rise_t >= 400 * D) rel_t = cyc;
        end
        if (dev_cnt > 0) dev_cnt--;
        case (dev_mode)
            M_SLOT:  dev_low = (dev_cnt > 0);
            M_PRES:  dev_low = (cyc - rel_t >= 20 * D) && (cyc - rel_t < 140 * D);
            M_STUCK: dev_low = 1'b1;
            default: dev_low = 1'b0;
        endcase
        if (ifc.done) done_cnt++;
        if (ifc.busy) busy_cyc++;
        if (ifc.busy && !ifc.done && ifc.rdata != rdata_p) rdata_chg++;
        rdata_p = ifc.rdata;
        pull_p  = ifc.busPullLow;
    end

    task automatic clear_mon();
        lows.delete();
        periods.delete();
        have_rise = 0;
        slot_i    = 0;
        dev_cnt   = 0;
        rel_t     = -1000000;
        done_cnt  = 0;
        busy_cyc  = 0;
        rdata_chg = 0;
    endtask

    task automatic wait_done(input int limit, input int inject);
        for (int i = 0; i < limit && done_cnt == 0; i++) begin
            @(negedge clk);
            if (inject != 0 && i == inject) begin
                ifc.cmdWrite = 1'b1;
                ifc.cmd      = 2'b10;
                ifc.wdata    = 8'h00;
            end else begin
                ifc.cmdWrite = 1'b0;
            end
            #1;
        end
        ifc.cmdWrite = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] wd);
        @(negedge clk);
        ifc.cmdWrite = 1'b1;
        ifc.cmd      = c;
        ifc.wdata    = wd;
        @(negedge clk);
        ifc.cmdWrite = 1'b0;
        #1;
    endtask

    task automatic do_cmd(input vec_t v, input string nm);
        logic [7:0] wd;
        int nsl, exp_busy, exp_low;
        wd       = v.wd;
        nsl      = (v.cmd == 2'b10) ? 8 : 1;
        exp_busy = (v.cmd == 2'b01) ? 960 * D : nsl * 65 * D;
        dev_mode = v.mode;
        dev_mask = v.mask;
        clear_mon();
        issue(v.cmd, v.wd);
        chk({nm, " busy_after_accept"}, ifc.busy == 1'b1, int'(ifc.busy), 1);
        chk({nm, " pull_after_accept"}, ifc.busPullLow == 1'b1, int'(ifc.busPullLow), 1);
        wait_done(LIMIT, v.inject);
        chk({nm, " done_seen"}, done_cnt != 0, done_cnt, 1);
        repeat (4) @(negedge clk);
        #1;
        chk({nm, " done_count"}, done_cnt == 1, done_cnt, 1);
        chk({nm, " busy_len"}, busy_cyc == exp_busy || busy_cyc == exp_busy + 1, busy_cyc, exp_busy);
        chk({nm, " rdata"}, ifc.rdata == v.exp_rdata, int'(ifc.rdata), int'(v.exp_rdata));
        chk({nm, " presence"}, ifc.presence == v.exp_pres, int'(ifc.presence), int'(v.exp_pres));
        chk({nm, " rdata_stable"}, rdata_chg == 0, rdata_chg, 0);
        chk({nm, " shortError"}, ifc.shortError == 1'b0, int'(ifc.shortError), 0);
        if (v.cmd == 2'b01) begin
            chk({nm, " low_pulses"}, lows.size() == 1, lows.size(), 1);
            if (lows.size() == 1) chk({nm, " reset_low"}, lows[0] == 480 * D, lows[0], 480 * D);
        end else begin
            chk({nm, " low_pulses"}, lows.size() == nsl, lows.size(), nsl);
            if (lows.size() == nsl) begin
                for (int i = 0; i < nsl; i++) begin
                    exp_low = (wd[i] ? 6 : 60) * D;
                    chk($sformatf("%s slot%0d_low", nm, i), lows[i] == exp_low, lows[i], exp_low);
                end
            end
            for (int i = 0; i < periods.size(); i++)
                chk($sformatf("%s period%0d", nm, i), periods[i] == 65 * D, periods[i], 65 * D);
        end
        cur_pres = v.exp_pres;
        dev_mode = M_NONE;
    endtask

    initial begin
        vec_t v;
        logic [7:0] rd_save;
        reset        = 1'b1;
        ifc.cmdWrite = 1'b0;
        ifc.cmd      = 2'b00;
        ifc.wdata    = 8'h00;

        vecs[0] = '{cmd:2'b01, wd:8'h00, mode:M_PRES, mask:8'h00, inject:0,   exp_rdata:8'h00, exp_pres:1'b1};
        vecs[1] = '{cmd:2'b10, wd:8'hA5, mode:M_NONE, mask:8'h00, inject:0,   exp_rdata:8'hA5, exp_pres:1'b1};
        vecs[2] = '{cmd:2'b10, wd:8'h5A, mode:M_NONE, mask:8'h00, inject:0,   exp_rdata:8'h5A, exp_pres:1'b1};
        vecs[3] = '{cmd:2'b01, wd:8'h00, mode:M_NONE, mask:8'h00, inject:0,   exp_rdata:8'h5A, exp_pres:1'b0};
        vecs[4] = '{cmd:2'b10, wd:8'hFF, mode:M_SLOT, mask:8'hC3, inject:0,   exp_rdata:8'h3C, exp_pres:1'b0};
        vecs[5] = '{cmd:2'b01, wd:8'h00, mode:M_PRES, mask:8'h00, inject:100, exp_rdata:8'h3C, exp_pres:1'b1};
        vecs[6] = '{cmd:2'b11, wd:8'h01, mode:M_NONE, mask:8'h00, inject:0,   exp_rdata:8'h01, exp_pres:1'b1};
        vecs[7] = '{cmd:2'b11, wd:8'h01, mode:M_SLOT, mask:8'h01, inject:0,   exp_rdata:8'h00, exp_pres:1'b1};
        vecs[8] = '{cmd:2'b11, wd:8'hFE, mode:M_NONE, mask:8'h00, inject:0,   exp_rdata:8'h00, exp_pres:1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst busPullLow", ifc.busPullLow == 1'b0, int'(ifc.busPullLow), 0);
        chk("rst busy", ifc.busy == 1'b0, int'(ifc.busy), 0);
        chk("rst done", ifc.done == 1'b0, int'(ifc.done), 0);
        chk("rst presence", ifc.presence == 1'b0, int'(ifc.presence), 0);
        chk("rst shortError", ifc.shortError == 1'b0, int'(ifc.shortError), 0);
        chk("rst rdata", ifc.rdata == 8'h00, int'(ifc.rdata), 0);
        cur_pres = 1'b0;

        for (int i = 0; i < 9; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));

        // Nop is ignored
        clear_mon();
        issue(2'b00, 8'h00);
        repeat (20) @(negedge clk);
        #1;
        chk("nop busy", ifc.busy == 1'b0, int'(ifc.busy), 0);
        chk("nop done", done_cnt == 0, done_cnt, 0);
        chk("nop pull", have_rise == 0, int'(have_rise), 0);

        // New command accepted on the done cycle
        clear_mon();
        issue(2'b11, 8'h01);
        wait_done(LIMIT, 0);
        chk("b2b first_done", ifc.done == 1'b1, int'(ifc.done), 1);
        chk("b2b first_rdata", ifc.rdata == 8'h01, int'(ifc.rdata), 1);
        ifc.cmdWrite = 1'b1;
        ifc.cmd      = 2'b11;
        ifc.wdata    = 8'h00;
        @(negedge clk);
        ifc.cmdWrite = 1'b0;
        #1;
        chk("b2b busy", ifc.busy == 1'b1, int'(ifc.busy), 1);
        chk("b2b pull", ifc.busPullLow == 1'b1, int'(ifc.busPullLow), 1);
        done_cnt = 0;
        wait_done(LIMIT, 0);
        chk("b2b second_rdata", ifc.rdata == 8'h00, int'(ifc.rdata), 0);

        // Randomized bytes and bits against the slot-level model
        for (int r = 0; r < 6; r++) begin
            v.cmd    = (r % 3 == 2) ? 2'b11 : 2'b10;
            v.wd     = 8'($urandom);
            v.mask   = 8'($urandom);
            v.mode   = M_SLOT;
            v.inject = 0;
            v.exp_rdata = (v.cmd == 2'b10) ? (v.wd & ~v.mask) : {7'b0, v.wd[0] & ~v.mask[0]};
            v.exp_pres  = cur_pres;
            do_cmd(v, $sformatf("rnd%0d", r));
        end

        // Bus stuck low
        dev_mode = M_STUCK;
        repeat (4) @(negedge clk);
`ifdef ONE_WIRE_SHORT_DETECT_EN
        clear_mon();
        rd_save = ifc.rdata;
        issue(2'b11, 8'h01);
        chk("short pull_at_accept", ifc.busPullLow == 1'b0, int'(ifc.busPullLow), 0);
        @(negedge clk);
        #1;
        chk("short done_latency", ifc.done == 1'b1, int'(ifc.done), 1);
        chk("short flag", ifc.shortError == 1'b1, int'(ifc.shortError), 1);
        chk("short rdata", ifc.rdata == rd_save, int'(ifc.rdata), int'(rd_save));
        repeat (4) @(negedge clk);
        #1;
        chk("short never_pulled", have_rise == 0, int'(have_rise), 0);
        chk("short done_count", done_cnt == 1, done_cnt, 1);
        dev_mode = M_NONE;
        repeat (4) @(negedge clk);
        v = '{cmd:2'b11, wd:8'h01, mode:M_NONE, mask:8'h00, inject:0, exp_rdata:8'h01, exp_pres:cur_pres};
        do_cmd(v, "short_clear");
`else
        rd_save = ifc.rdata;
        v = '{cmd:2'b11, wd:8'h01, mode:M_STUCK, mask:8'h00, inject:0, exp_rdata:8'h00, exp_pres:cur_pres};
        do_cmd(v, "stuck_bit");
        v = '{cmd:2'b01, wd:8'h00, mode:M_STUCK, mask:8'h00, inject:0, exp_rdata:8'h00, exp_pres:1'b1};
        do_cmd(v, "stuck_reset");
        dev_mode = M_NONE;
        repeat (4) @(negedge clk);
`endif

        // Async reset during a 0-slot
        clear_mon();
        issue(2'b11, 8'h00);
        repeat (3 * D) @(posedge clk);
        #2;
        chk("areset pull_before", ifc.busPullLow == 1'b1, int'(ifc.busPullLow), 1);
        reset = 1'b1;
        #1;
        chk("areset pull", ifc.busPullLow == 1'b0, int'(ifc.busPullLow), 0);
        chk("areset busy", ifc.busy == 1'b0, int'(ifc.busy), 0);
        chk("areset presence", ifc.presence == 1'b0, int'(ifc.presence), 0);
        chk("areset rdata", ifc.rdata == 8'h00, int'(ifc.rdata), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/one_wire_master.md
# one_wire_master

Hardware 1-wire bus master that sequences reset/presence, byte and single-bit slots on one open-drain 1-wire pin (DS2433 or DS2401 bus). It replaces host bit-banging of the DS bus register. One instance sits per pin, between the host register decoder and the pin's pull-low driver. The host issues a command, polls `busy` or waits for `done`, then reads `rdata`/`presence`.

## Interface
- `US_DIVIDER`, 29: clk cycles per microsecond tick (must be ≥2).
- `RESET_LOW_US`, 480: reset pulse low time.
- `PRESENCE_SAMPLE_US`, 70: presence sample point, measured from reset release.
- `RESET_RELEASE_US`, 480: release phase length after the reset pulse.
- `SLOT_US`, 65: total time-slot length.
- `WRITE1_LOW_US`, 6: low time for a 1 bit (also used for read slots).
- `WRITE0_LOW_US`, 60: low time for a 0 bit.
- `SAMPLE_US`, 15: slot sample point, measured from slot start.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmdWrite` in 1: one-cycle command strobe.
- `cmd` in 2: 00 nop, 01 reset/presence, 10 byte, 11 bit.
- `wdata` in 8: byte to send, LSB first. A bit command uses `wdata[0]`. A read is a write of 1s.
- `rdata` out 8: sampled data.
- `presence` out 1: device answered the last reset.
- `shortError` out 1: bus found stuck low (see Configuration).
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.
- `busIn` in 1: raw pin level, asynchronous.
- `busPullLow` out 1: 1 drives the pin low; 0 releases it.

## Operation
- `busIn` passes through a 2-flop synchronizer, giving `busSync`. All samples use `busSync`.
- Microsecond prescaler counts 0..`US_DIVIDER`-1 and emits a tick on the terminal count. It is cleared on command accept, so every phase lasts exactly N×`US_DIVIDER` cycles.
- A 10-bit µs counter `t` is cleared at each phase or slot start.
- States:
  - IDLE: accepts `cmdWrite` with cmd≠00. Nop is ignored.
  - RST_LOW: pull low until t=`RESET_LOW_US`, then go to RST_REL with t cleared.
  - RST_REL: released. At t=`PRESENCE_SAMPLE_US`, `presence` ← ~busSync. At t=`RESET_RELEASE_US`, go to IDLE.
  - SLOT: pull low while t < lowTime, where lowTime is `WRITE1_LOW_US` or `WRITE0_LOW_US` per the current bit. At t=`SAMPLE_US`, latch the bit. At t=`SLOT_US`, either start the next slot (t cleared, no gap) or go to IDLE.
- Byte command: 8 slots, LSB first. Each sample shifts into a working register from bit 7 (shift right).
- Bit command: one slot. On completion `rdata` = {7'b0, sample}.
- A reset command leaves `rdata` unchanged. A byte/bit command leaves `presence` unchanged.
- `rdata` updates only on the completion cycle. It does not change mid-byte.
- `cmdWrite` while `busy` is dropped silently. State, outputs and the pending command are unaffected.

## Timing
- Reset values: busPullLow 0, busy 0, done 0, presence 0, shortError 0, rdata 0x00, state IDLE. Async reset clears busPullLow without waiting for a clock edge.
- Accept at edge k: `busy` and `busPullLow` are 1 after edge k (registered outputs).
- Reset command: busPullLow high for exactly `RESET_LOW_US`×`US_DIVIDER` cycles. Total busy time is (`RESET_LOW_US`+`RESET_RELEASE_US`)×`US_DIVIDER` cycles (+1 for the IDLE transition).
- Slot: low for lowTime×`US_DIVIDER` cycles. Slot period is `SLOT_US`×`US_DIVIDER` cycles. A byte takes 8 back-to-back slots.
- Sample point: `busSync` at the tick where t reaches the sample value. Pin-to-sample latency is 2 cycles.
- `done` pulses on the cycle `busy` falls. A new command is accepted on that same cycle at the earliest (busy is 0 when sampled).
- Simultaneous `reset` and `cmdWrite`: reset wins and the command is lost.

## Configuration
- `ONE_WIRE_SHORT_DETECT_EN`:
  - Defined: on accept, and at every slot start, if busSync=0 the block aborts. It sets `shortError`=1, releases the bus, returns to IDLE and pulses `done` on the next cycle. `rdata`/`presence` stay unchanged. `shortError` is cleared by the next accepted command.
  - Undefined: no check is made, `shortError` is tied 0, and the stuck-low bus simply reads as 0 bits and presence.

## Test plan
- Reset, with a device model pulling low from 20–140 µs after release -> presence=1; busPullLow high 480×29 cycles; done after 960×29(+1) cycles.
- Reset with no device -> presence=0, rdata unchanged from its prior value 0x5A.
- Byte 0xA5 -> low pulses of 6,60,6,60,60,6,60,6 µs, slot period 65 µs; done once at the end of slot 8.
- Byte 0xFF, with the model holding low to 30 µs in the slots for the 0 bits of 0x3C -> rdata=0x3C, unchanged until done.
- cmdWrite (byte 0x00) mid-reset -> ignored; reset timing and result identical to the first scenario; exactly one done.
- Async reset asserted 3 µs into a 0-slot -> busPullLow=0 before the next clk edge, busy=0. With `ONE_WIRE_SHORT_DETECT_EN`: bus held low, then bit command -> shortError=1, done 1 cycle after accept, busPullLow never asserted.
